regfile_write_queue: RTL and testbench

//  Write-back buffer directly upstream of register_block. Accepts results from the execute

---
 rtl/regfile_write_queue.sv | 130 +++++++++++++
 tb/tb_regfile_write_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write-back buffer draining one result per cycle into register_block.
// Define WQ_BYPASS_EN to compile in the pending-write lookup on ReadReg1/ReadReg2.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     wb_hold,
  output logic                     RegWrite,
  output logic [AW-1:0]            WriteReg,
  output logic [DW-1:0]            WriteData,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            ReadReg1,
  input  logic [AW-1:0]            ReadReg2,
  output logic                     fwd_hit1,
  output logic [DW-1:0]            fwd_data1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] rdPtrReg, rdPtrNext;
  logic [PW-1:0] wrPtrReg, wrPtrNext;
  logic [CW-1:0] countReg, countNext;
  logic [AW-1:0] regMem  [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic          notEmpty, full, push, pop;

  assign notEmpty = (countReg != '0);
  assign full     = (countReg == FULL_COUNT);
  assign push     = in_valid && !full;
  assign pop      = notEmpty && !wb_hold;

  // Head is presented combinationally; an entry pushed this edge shows up next cycle.
  assign in_ready  = !full;
  assign RegWrite  = pop;
  assign WriteReg  = notEmpty ? regMem[rdPtrReg]  : '0;
  assign WriteData = notEmpty ? dataMem[rdPtrReg] : '0;
  assign count     = countReg;

  always_comb begin
    rdPtrNext = rdPtrReg;
    wrPtrNext = wrPtrReg;
    countNext = countReg;
    if (push) wrPtrNext = wrPtrReg + PW'(1);
    if (pop)  rdPtrNext = rdPtrReg + PW'(1);
    case ({push, pop})
      2'b10:   countNext = countReg + CW'(1);
      2'b01:   countNext = countReg - CW'(1);
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      countReg <= '0;
    end else begin
      rdPtrReg <= rdPtrNext;
      wrPtrReg <= wrPtrNext;
      countReg <= countNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regMem[i]  <= '0;
        dataMem[i] <= '0;
      end
    end else if (push) begin
      regMem[wrPtrReg]  <= in_reg;
      dataMem[wrPtrReg] <= in_data;
    end
  end

`ifdef WQ_BYPASS_EN
  logic [DEPTH-1:0] entryLive, match1, match2;

  // A slot is live when its distance from the head is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic [PW-1:0] age;
      assign age           = PW'(gi) - rdPtrReg;
      assign entryLive[gi] = ({1'b0, age} < countReg);
      assign match1[gi]    = entryLive[gi] && (regMem[gi] == ReadReg1);
      assign match2[gi]    = entryLive[gi] && (regMem[gi] == ReadReg2);
    end
  endgenerate

  // Walk oldest to youngest so the last match (closest to wrPtr) wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot      = rdPtrReg;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rdPtrReg + PW'(k);
      if (match1[slot]) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = dataMem[slot];
      end
      if (match2[slot]) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = dataMem[slot];
      end
    end
  end
`else
  logic unusedReadRegs;
  assign unusedReadRegs = ^{ReadReg1, ReadReg2};
  assign fwd_hit1  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: directed scenarios plus randomized traffic against a queue model.
module tb_regfile_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 32;
`ifdef WQ_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [AW-1:0] in_reg = '0;
  logic [DW-1:0] in_data = '0;
  logic wb_hold = 1'b0;
  logic RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [$clog2(DEPTH):0] count;
  logic [AW-1:0] ReadReg1 = '0, ReadReg2 = '0;
  logic fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;

  always #5 clk = ~clk;

  regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_hold(wb_hold),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .count(count),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t modelQ[$];   // pending writes as the reference sees them
  wr_t expQ[$];     // retire-order scoreboard consumed by the monitor
  int  nChecks = 0;
  int  nFails  = 0;
  bit  checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    foreach (modelQ[i]) begin
      if (BYPASS_ON && modelQ[i].r == ra) begin
        hit  = 1'b1;
        data = modelQ[i].d;
      end
    end
  endfunction

  // One cycle of stimulus; the model steps at the edge using the queue rules.
  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                       input logic h, input logic [AW-1:0] rr1, input logic [AW-1:0] rr2);
    int pre;
    wr_t e;
    in_valid = v; in_reg = r; in_data = d; wb_hold = h;
    ReadReg1 = rr1; ReadReg2 = rr2;
    @(posedge clk);
    pre = modelQ.size();
    if (pre != 0 && !h) void'(modelQ.pop_front());
    if (v && pre < DEPTH) begin
      e.r = r;
      e.d = d;
      modelQ.push_back(e);
      expQ.push_back(e);
    end
    #1;
  endtask

  // Monitor: compare every cycle on the falling edge, retire from the scoreboard on each write.
  logic          monExpWr, monHit;
  logic [DW-1:0] monData, monIdle;
  wr_t           monE;
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        monExpWr = (modelQ.size() != 0) && !wb_hold;
        check("RegWrite", 64'(RegWrite), 64'(monExpWr));
        check("count", 64'(count), 64'(modelQ.size()));
        check("in_ready", 64'(in_ready), 64'(modelQ.size() != DEPTH));
        if (RegWrite) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL stray_write: got reg %0d data 0x%0h expected no write at %0t", WriteReg, WriteData, $time);
          end else begin
            monE = expQ.pop_front();
            check("WriteReg", 64'(WriteReg), 64'(monE.r));
            check("WriteData", 64'(WriteData), 64'(monE.d));
          end
        end else begin
          monIdle = (modelQ.size() != 0) ? modelQ[0].d : '0;
          check("WriteData_idle", 64'(WriteData), 64'(monIdle));
        end
        lookup(ReadReg1, monHit, monData);
        check("fwd_hit1", 64'(fwd_hit1), 64'(monHit));
        check("fwd_data1", 64'(fwd_data1), 64'(monData));
        lookup(ReadReg2, monHit, monData);
        check("fwd_hit2", 64'(fwd_hit2), 64'(monHit));
        check("fwd_data2", 64'(fwd_data2), 64'(monData));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_RegWrite", 64'(RegWrite), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_WriteData", 64'(WriteData), 64'd0);
    check("rst_fwd_hit1", 64'(fwd_hit1), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    // Single push, visible the following cycle only
    drive(1, 3, 30, 0, 0, 0);
    check("t2_RegWrite", 64'(RegWrite), 64'd1);
    check("t2_WriteReg", 64'(WriteReg), 64'd3);
    check("t2_WriteData", 64'(WriteData), 64'd30);
    drive(0, 0, 0, 0, 0, 0);
    check("t2_drained", 64'(count), 64'd0);
    drive(0, 0, 0, 0, 0, 0);

    // Fill under hold, refuse a fifth push, then drain in order
    for (int i = 0; i < 4; i++) drive(1, AW'(i), DW'(10 + i), 1, 0, 1);
    check("t3_full_count", 64'(count), 64'd4);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    drive(1, 7, 99, 1, 0, 0);
    check("t3_refused", 64'(count), 64'd4);
    repeat (5) drive(0, 0, 0, 0, 0, 0);

    // Full with pop: push refused that cycle, accepted the next; pointers wrap
    for (int i = 0; i < 4; i++) drive(1, AW'(i), DW'(20 + i), 1, 2, 3);
    drive(1, 4, 24, 0, 1, 4);
    check("t4_after_pop", 64'(count), 64'd3);
    drive(1, 5, 25, 0, 5, 0);
    check("t4_push_pop", 64'(count), 64'd3);
    repeat (5) drive(0, 0, 0, 0, 0, 0);

    // Two pending writes to the same register: youngest forwarded
    drive(1, 5, 100, 1, 5, 6);
    drive(1, 5, 200, 1, 5, 6);
    check("t5_fwd_hit1", 64'(fwd_hit1), 64'(BYPASS_ON));
    check("t5_fwd_data1", 64'(fwd_data1), BYPASS_ON ? 64'd200 : 64'd0);
    check("t5_fwd_hit2", 64'(fwd_hit2), 64'd0);
    repeat (3) drive(0, 0, 0, 0, 5, 6);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 2 * DEPTH && modelQ.size() != 0; n++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("drain_scoreboard_empty", 64'(expQ.size()), 64'd0);

    // Reset while three entries are pending and draining
    for (int i = 0; i < 3; i++) drive(1, AW'(i + 1), DW'(40 + i), 1, 0, 0);
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    #1;
    check("t6_pre_wr", 64'(RegWrite), 64'd1);
    check("t6_pre_count", 64'(count), 64'd3);
    checking = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_RegWrite", 64'(RegWrite), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_WriteData", 64'(WriteData), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    modelQ.delete();
    expQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;
    repeat (6) drive(0, 0, 0, 0, 1, 2);
    drive(1, 6, 66, 0, 6, 6);
    repeat (3) drive(0, 0, 0, 0, 6, 6);
    check("final_scoreboard_empty", 64'(expQ.size()), 64'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
